// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and default width.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } ser_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout set when the bit position underflows.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first: one full_subtractor cell plus a registered borrow.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_e       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] res_sh_d;
    logic             bor_q;
    logic             bor_d;
    logic             d_bit;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bor_q),
        .d    (d_bit),
        .bout (bor_d)
    );

    // New result bit enters at the top so the LSB lands in bit 0 after WIDTH shifts.
    assign res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            bor_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        res_sh_q <= '0;
                        bor_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= res_sh_d;
                    bor_q    <= bor_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        diff_q  <= res_sh_d;
                        bout_q  <= bor_d;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed cases plus random regression against an arithmetic reference.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, bor8;
    logic [7:0]  diff8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, bor16;
    logic [15:0] diff16;

    logic        fx = 1'b0, fy = 1'b0, fbin = 1'b0;
    logic        fd, fbout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bor16)
    );

    full_subtractor u_fs (
        .x(fx), .y(fy), .bin(fbin), .d(fd), .bout(fbout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [31:0] diff_of(input int w);
        return (w == 8) ? {24'd0, diff8} : {16'd0, diff16};
    endfunction

    function automatic logic bor_of(input int w);
        return (w == 8) ? bor8 : bor16;
    endfunction

    task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start16 = s; a16 = a; b16 = b;
        end
    endtask

    // One full transaction: accept, scramble inputs while busy, then check latency and result.
    task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [31:0] mask, exp_d, ua, ub;
        int lat;
        logic seen;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        ua    = {16'd0, a} & mask;
        ub    = {16'd0, b} & mask;
        exp_d = (ua - ub) & mask;
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, busy_of(w)}, 32'd0);
        drive(w, 1'b1, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, ~a, ~b);
        lat  = 0;
        seen = 1'b0;
        while (lat <= w + 5) begin
            @(negedge clk);
            if (done_of(w)) begin
                seen = 1'b1;
                break;
            end
            if (lat == 0) chk({tag, "_busy"}, {31'd0, busy_of(w)}, 32'd1);
            lat++;
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, lat, w);
            chk({tag, "_diff"}, diff_of(w), exp_d);
            chk({tag, "_borrow"}, {31'd0, bor_of(w)}, {31'd0, (ua < ub)});
            @(negedge clk);
            chk({tag, "_pulse_end"}, {31'd0, done_of(w)}, 32'd0);
            chk({tag, "_hold"}, diff_of(w), exp_d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, last, npulse;
        logic seen;
        logic [15:0] ra, rb;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy8", {31'd0, busy8}, 0);
        chk("rst_done8", {31'd0, done8}, 0);
        chk("rst_diff8", {24'd0, diff8}, 0);
        chk("rst_bor8", {31'd0, bor8}, 0);
        chk("rst_busy16", {31'd0, busy16}, 0);
        chk("rst_diff16", {16'd0, diff16}, 0);

        // Exhaustive check of the single-bit cell.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            fx = v[2]; fy = v[1]; fbin = v[0];
            #1;
            chk($sformatf("fs_d_%0d", i), {31'd0, fd}, {31'd0, ^v});
            chk($sformatf("fs_bout_%0d", i), {31'd0, fbout},
                {31'd0, (i == 1 || i == 2 || i == 3 || i == 7)});
        end

        op(8, 16'h005A, 16'h003C, "t1");
        op(8, 16'h0000, 16'h0001, "t2a");
        op(8, 16'h00FF, 16'h00FF, "t2b");

        // Start held high: operations back to back, one done every WIDTH+2 cycles.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        last = -1;
        npulse = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done8) begin
                npulse++;
                chk("t3_diff", {24'd0, diff8}, 32'hF0);
                chk("t3_borrow", {31'd0, bor8}, 1);
                if (last >= 0) chk("t3_period", cyc - last, 10);
                last = cyc;
            end
        end
        start8 = 1'b0;
        chk("t3_pulses", npulse, 4);
        repeat (12) @(negedge clk);

        // Reset four cycles into a computation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        @(posedge clk);
        #1 start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_busy", {31'd0, busy8}, 0);
        chk("t4_done", {31'd0, done8}, 0);
        chk("t4_diff", {24'd0, diff8}, 0);
        chk("t4_borrow", {31'd0, bor8}, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        chk("t4_no_done", {31'd0, seen}, 0);
        op(8, 16'h00C3, 16'h0042, "t4_after");

        op(16, 16'h0000, 16'hFFFF, "w16_corner_a");
        op(16, 16'hFFFF, 16'h0000, "w16_corner_b");
        op(16, 16'h8000, 16'h8001, "w16_corner_c");

        // Random regression on both widths.
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            op(8, ra, rb, "rnd8");
        end
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            op(16, ra, rb, "rnd16");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
